mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences all traffic to a single shared, single-ported memory in the pipelined MIPS core.
- Serves two requesters: instruction fetch (IF stage) and data load/store (MEM stage).
- Grants one access at a time, holds the memory-side request stable until the memory acknowledges, and returns data with a one-cycle ready pulse.
- The pipeline stalls a stage while that stage's request is high and its ready is low.

Parameters:
- MAX_DATA_BURST, 4: number of consecutive data grants allowed while a fetch is pending; after that, the next grant goes to IF.
- TIMEOUT, 16: number of wait cycles without mem_ack before the access is aborted.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; held until if_ready.
- if_addr  input  32  fetch address.
- if_rdata  output  32  fetched instruction; valid while if_ready=1.
- if_ready  output  1  one-cycle fetch completion pulse.
- dm_read  input  1  data load request; held until dm_ready.
- dm_write  input  1  data store request; held until dm_ready.
- dm_addr  input  32  data address.
- dm_wdata  input  32  store data.
- dm_rdata  output  32  load data; valid while dm_ready=1.
- dm_ready  output  1  one-cycle data completion pulse.
- mem_req  output  1  memory request; held until mem_ack.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr  output  32  memory address.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data; valid while mem_ack=1.
- mem_ack  input  1  memory completion; single-cycle pulse.
- err  output  1  sticky timeout flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE immediately.
  - mem_req, mem_we, if_ready, dm_ready and err clear to 0.
  - mem_addr, mem_wdata, if_rdata and dm_rdata clear to 0.
  - Burst counter and timeout counter clear to 0.
  - Reset asserted mid-access drops mem_req at once, without waiting for a clock edge. Any later mem_ack for that aborted access is ignored.
- All outputs are registered.
- States: IDLE, WAIT_D, WAIT_I, RESP.
- IDLE arbitration, evaluated on each rising edge:
  - If data pending (dm_read|dm_write) and NOT (if_req and burst_cnt==MAX_DATA_BURST): grant data, go to WAIT_D.
  - Else if if_req: grant IF, go to WAIT_I, clear burst_cnt.
  - Else if data is pending: grant data (this covers data pending while burst_cnt==MAX_DATA_BURST but if_req low).
  - Otherwise stay in IDLE.
- Data grant details:
  - Latch mem_addr=dm_addr, mem_wdata=dm_wdata, mem_we=dm_write, and set mem_req=1.
  - dm_read and dm_write both high is treated as a write.
  - burst_cnt increments, saturating at MAX_DATA_BURST, if if_req=1 at the grant edge; otherwise it clears to 0.
- IF grant details: latch mem_addr=if_addr, mem_we=0, mem_req=1; mem_wdata is unchanged.
- WAIT_D / WAIT_I:
  - mem_addr, mem_we, mem_wdata and mem_req are held constant.
  - The timeout counter increments each cycle without mem_ack.
  - On mem_ack:
    - mem_req<=0 and state goes to RESP.
    - The matching ready is set for exactly the RESP cycle.
    - For a read, mem_rdata is captured into dm_rdata or if_rdata.
    - For a write, dm_rdata retains its previous value.
  - On timeout counter reaching TIMEOUT with no ack:
    - mem_req<=0, err<=1, and state goes to RESP.
    - The matching ready is asserted with rdata=0.
- RESP:
  - Exactly one cycle; requests are ignored.
  - Requesters advance on the edge ending RESP.
  - Next state is IDLE; the timeout counter clears.
- Latency: grant edge, then at least one wait cycle, then RESP. Minimum 3 cycles from request visible in IDLE to ready. With ack arriving k cycles after the grant edge, ready is high in cycle k+1.
- mem_ack outside WAIT states is ignored.
- err stays 1 until reset.

Test Plan:
1. Single fetch: if_req=1, if_addr=0x40. Memory acks 1 cycle after mem_req with 0x8C010004. Expect mem_req=1, mem_we=0, mem_addr=0x40, then if_ready pulse with if_rdata=0x8C010004, 3 cycles after request.
2. Simultaneous requests in IDLE: if_req plus dm_write (addr 0x100, wdata 0x12345678). Expect data granted first (mem_we=1, mem_addr=0x100, mem_wdata=0x12345678), dm_ready pulse, then fetch granted, if_ready pulse.
3. Starvation guard: if_req held high, dm_read continuously asserted, MAX_DATA_BURST=4. Expect exactly 4 data grants, then 1 IF grant, then data resumes with burst_cnt=1.
4. Timeout: dm_read at 0x200, mem_ack never asserted, TIMEOUT=16. Expect mem_req high for 16 wait cycles then low, dm_ready pulse with dm_rdata=0, err=1 and staying high.
5. Reset mid-access: reset=0 asserted in WAIT_I between clock edges. Expect mem_req=0 immediately, state IDLE, err=0. A later mem_ack produces no ready pulse.
6. Ready-pulse width: ack arrives 5 cycles after grant. Expect mem_req held with a stable address for 5 cycles, ready high for exactly 1 cycle, and no re-grant in the RESP cycle even though the request is still high.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter for the single-ported shared memory: instruction fetch vs. data load/store.
// Holds the memory request stable until ack or timeout and returns a one-cycle ready pulse.
module mem_arbiter #(
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_read,
    input  logic        dm_write,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);
    localparam int BW = $clog2(MAX_DATA_BURST + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_D, WAIT_I, RESP} state_t;

    state_t          r_state, w_next;
    logic [BW-1:0]   r_burst_cnt, w_burst_nx;
    logic [TW-1:0]   r_tmo_cnt, w_tmo_nx;

    logic            w_dm_pend, w_if_starve, w_grant_d, w_grant_i;
    logic            w_in_wait, w_ack, w_tmo, w_done;

    logic            w_mem_req_nx, w_mem_we_nx, w_if_ready_nx, w_dm_ready_nx, w_err_nx;
    logic [31:0]     w_mem_addr_nx, w_mem_wdata_nx, w_if_rdata_nx, w_dm_rdata_nx;

    assign w_dm_pend   = dm_read | dm_write;
    assign w_if_starve = if_req && (r_burst_cnt == BW'(MAX_DATA_BURST));
    assign w_in_wait   = (r_state == WAIT_D) || (r_state == WAIT_I);
    assign w_ack       = w_in_wait && mem_ack;
    // Abort on the cycle in which the wait counter would reach TIMEOUT.
    assign w_tmo       = w_in_wait && !mem_ack && (r_tmo_cnt == TW'(TIMEOUT - 1));
    assign w_done      = w_ack || w_tmo;

    always_comb begin
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        if (r_state == IDLE) begin
            if (w_dm_pend && !w_if_starve) w_grant_d = 1'b1;
            else if (if_req)               w_grant_i = 1'b1;
            else if (w_dm_pend)            w_grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d)      w_next = WAIT_D;
                else if (w_grant_i) w_next = WAIT_I;
            end
            WAIT_D, WAIT_I: if (w_done) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_mem_req_nx   = mem_req;
        w_mem_we_nx    = mem_we;
        w_mem_addr_nx  = mem_addr;
        w_mem_wdata_nx = mem_wdata;
        w_if_ready_nx  = 1'b0;
        w_dm_ready_nx  = 1'b0;
        w_if_rdata_nx  = if_rdata;
        w_dm_rdata_nx  = dm_rdata;
        w_err_nx       = err;
        w_burst_nx     = r_burst_cnt;
        w_tmo_nx       = r_tmo_cnt;

        if (w_grant_d) begin
            w_mem_req_nx   = 1'b1;
            w_mem_we_nx    = dm_write;
            w_mem_addr_nx  = dm_addr;
            w_mem_wdata_nx = dm_wdata;
            if (!if_req)
                w_burst_nx = '0;
            else if (r_burst_cnt != BW'(MAX_DATA_BURST))
                w_burst_nx = r_burst_cnt + BW'(1);
        end
        if (w_grant_i) begin
            w_mem_req_nx  = 1'b1;
            w_mem_we_nx   = 1'b0;
            w_mem_addr_nx = if_addr;
            w_burst_nx    = '0;
        end

        if (w_in_wait && !mem_ack)
            w_tmo_nx = r_tmo_cnt + TW'(1);
        if (r_state == RESP)
            w_tmo_nx = '0;

        if (w_done) begin
            w_mem_req_nx = 1'b0;
            if (r_state == WAIT_D) begin
                w_dm_ready_nx = 1'b1;
                if (w_tmo)        w_dm_rdata_nx = '0;
                else if (!mem_we) w_dm_rdata_nx = mem_rdata;
            end else begin
                w_if_ready_nx = 1'b1;
                w_if_rdata_nx = w_tmo ? 32'h0 : mem_rdata;
            end
            if (w_tmo) w_err_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_ready    <= 1'b0;
            dm_ready    <= 1'b0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
            err         <= 1'b0;
            r_burst_cnt <= '0;
            r_tmo_cnt   <= '0;
        end else begin
            mem_req     <= w_mem_req_nx;
            mem_we      <= w_mem_we_nx;
            mem_addr    <= w_mem_addr_nx;
            mem_wdata   <= w_mem_wdata_nx;
            if_ready    <= w_if_ready_nx;
            dm_ready    <= w_dm_ready_nx;
            if_rdata    <= w_if_rdata_nx;
            dm_rdata    <= w_dm_rdata_nx;
            err         <= w_err_nx;
            r_burst_cnt <= w_burst_nx;
            r_tmo_cnt   <= w_tmo_nx;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0, dm_read = 1'b0, dm_write = 1'b0, mem_ack = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ready, dm_ready, mem_req, mem_we, err;

    int n_vec = 0;
    int n_err = 0;

    mem_arbiter #(.MAX_DATA_BURST(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_read, dm_write;
        logic [31:0] dm_addr, dm_wdata, mem_rdata;
        logic        mem_ack;
        logic        e_req, e_we;
        logic [31:0] e_addr, e_wdata;
        logic        e_ifr;
        logic [31:0] e_ifd;
        logic        e_dmr;
        logic [31:0] e_dmd;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dw,
                                logic [31:0] da, logic [31:0] dwd, logic [31:0] mrd, logic ack,
                                logic req, logic we, logic [31:0] ea, logic [31:0] ew,
                                logic ifr, logic [31:0] ifd, logic dmr, logic [31:0] dmd, logic e);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.dm_read = dr; v.dm_write = dw;
        v.dm_addr = da; v.dm_wdata = dwd; v.mem_rdata = mrd; v.mem_ack = ack;
        v.e_req = req; v.e_we = we; v.e_addr = ea; v.e_wdata = ew;
        v.e_ifr = ifr; v.e_ifd = ifd; v.e_dmr = dmr; v.e_dmd = dmd; v.e_err = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Waits for a grant, optionally checks the hold period, then acks k cycles after the grant edge.
    task automatic serve(input int k, input logic [31:0] rd, output logic [31:0] a);
        int n = 0;
        while (!mem_req && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("grant_seen", {31'b0, mem_req}, 32'd1);
        a = mem_addr;
        for (int c = 1; c < k; c++) begin
            @(posedge clk); #1;
            chk("req_hold", {31'b0, mem_req}, 32'd1);
            chk("addr_hold", mem_addr, a);
        end
        mem_rdata = rd; mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    vec_t vt[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, exp_a;
        int cnt;

        vt[0]  = mk(1, 32'h40, 0, 0, 0, 0, 0, 0,
                    1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
        vt[1]  = mk(1, 32'h40, 0, 0, 0, 0, 32'h8C010004, 1,
                    0, 0, 32'h40, 0, 1, 32'h8C010004, 0, 0, 0);
        vt[2]  = mk(1, 32'h40, 0, 0, 0, 0, 0, 0,
                    0, 0, 32'h40, 0, 0, 32'h8C010004, 0, 0, 0);
        vt[3]  = mk(0, 32'h40, 0, 0, 0, 0, 0, 0,
                    0, 0, 32'h40, 0, 0, 32'h8C010004, 0, 0, 0);
        vt[4]  = mk(1, 32'h44, 0, 1, 32'h100, 32'h12345678, 0, 0,
                    1, 1, 32'h100, 32'h12345678, 0, 32'h8C010004, 0, 0, 0);
        vt[5]  = mk(1, 32'h44, 0, 1, 32'h100, 32'h12345678, 32'hFFFFFFFF, 1,
                    0, 1, 32'h100, 32'h12345678, 0, 32'h8C010004, 1, 0, 0);
        vt[6]  = mk(1, 32'h44, 0, 1, 32'h100, 32'h12345678, 0, 0,
                    0, 1, 32'h100, 32'h12345678, 0, 32'h8C010004, 0, 0, 0);
        vt[7]  = mk(1, 32'h44, 0, 0, 32'h100, 32'h12345678, 0, 0,
                    1, 0, 32'h44, 32'h12345678, 0, 32'h8C010004, 0, 0, 0);
        vt[8]  = mk(1, 32'h44, 0, 0, 32'h100, 32'h12345678, 32'h00221820, 1,
                    0, 0, 32'h44, 32'h12345678, 1, 32'h00221820, 0, 0, 0);
        vt[9]  = mk(0, 32'h44, 0, 0, 32'h100, 32'h12345678, 0, 0,
                    0, 0, 32'h44, 32'h12345678, 0, 32'h00221820, 0, 0, 0);
        vt[10] = mk(0, 32'h44, 0, 0, 32'h100, 32'h12345678, 32'hDEADBEEF, 1,
                    0, 0, 32'h44, 32'h12345678, 0, 32'h00221820, 0, 0, 0);

        // Reset state
        #2 reset = 1'b0;
        #2;
        chk("reset_flags", {27'b0, mem_req, mem_we, if_ready, dm_ready, err}, 32'd0);
        chk("reset_addr", mem_addr, 32'd0);
        chk("reset_rdata", if_rdata | dm_rdata | mem_wdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Single fetch, simultaneous IF + store, ack ignored in IDLE
        for (int i = 0; i < 11; i++) begin
            if_req = vt[i].if_req; if_addr = vt[i].if_addr;
            dm_read = vt[i].dm_read; dm_write = vt[i].dm_write;
            dm_addr = vt[i].dm_addr; dm_wdata = vt[i].dm_wdata;
            mem_rdata = vt[i].mem_rdata; mem_ack = vt[i].mem_ack;
            @(posedge clk); #1;
            n_vec++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, if_ready, if_rdata, dm_ready, dm_rdata, err} !==
                {vt[i].e_req, vt[i].e_we, vt[i].e_addr, vt[i].e_wdata, vt[i].e_ifr, vt[i].e_ifd,
                 vt[i].e_dmr, vt[i].e_dmd, vt[i].e_err}) begin
                n_err++;
                $display("FAIL vec%0d: got req=%b we=%b addr=%h wd=%h ifr=%b ifd=%h dmr=%b dmd=%h err=%b want req=%b we=%b addr=%h wd=%h ifr=%b ifd=%h dmr=%b dmd=%h err=%b",
                         i, mem_req, mem_we, mem_addr, mem_wdata, if_ready, if_rdata, dm_ready, dm_rdata, err,
                         vt[i].e_req, vt[i].e_we, vt[i].e_addr, vt[i].e_wdata, vt[i].e_ifr, vt[i].e_ifd,
                         vt[i].e_dmr, vt[i].e_dmd, vt[i].e_err);
            end
        end
        mem_ack = 1'b0; mem_rdata = '0;

        // Starvation guard: D D D D I D D D D I
        if_req = 1'b1; if_addr = 32'h80;
        dm_read = 1'b1; dm_write = 1'b0; dm_addr = 32'h200;
        for (int i = 0; i < 10; i++) begin
            serve(1, 32'hA0000000 + 32'(i), a);
            exp_a = (i == 4 || i == 9) ? 32'h80 : 32'h200;
            chk($sformatf("burst_grant%0d", i), a, exp_a);
            if (exp_a == 32'h80) begin
                chk("burst_ifready", {30'b0, if_ready, dm_ready}, 32'd2);
                chk("burst_ifdata", if_rdata, 32'hA0000000 + 32'(i));
            end else begin
                chk("burst_dmready", {30'b0, if_ready, dm_ready}, 32'd1);
                chk("burst_dmdata", dm_rdata, 32'hA0000000 + 32'(i));
            end
        end
        if_req = 1'b0; dm_read = 1'b0;
        @(posedge clk); #1;

        // Ack 5 cycles after grant; request still high during RESP must not re-grant
        dm_read = 1'b1; dm_addr = 32'h300;
        serve(5, 32'hCAFEF00D, a);
        chk("slow_addr", a, 32'h300);
        chk("slow_ready", {31'b0, dm_ready}, 32'd1);
        chk("slow_data", dm_rdata, 32'hCAFEF00D);
        @(posedge clk); #1;
        dm_read = 1'b0;
        chk("slow_pulse_width", {31'b0, dm_ready}, 32'd0);
        chk("slow_no_regrant", {31'b0, mem_req}, 32'd0);
        @(posedge clk); #1;

        // Timeout: no ack ever
        dm_read = 1'b1; dm_addr = 32'h200;
        cnt = 0;
        while (!mem_req && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("tmo_grant", {31'b0, mem_req}, 32'd1);
        cnt = 0;
        while (mem_req && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("tmo_req_cycles", 32'(cnt), 32'd16);
        chk("tmo_ready", {31'b0, dm_ready}, 32'd1);
        chk("tmo_rdata", dm_rdata, 32'd0);
        chk("tmo_err", {31'b0, err}, 32'd1);
        dm_read = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", {31'b0, err}, 32'd1);

        // Reset mid-access in WAIT_I, then a stray ack
        if_req = 1'b1; if_addr = 32'h500;
        @(posedge clk); #1;
        chk("rst_pre_req", {31'b0, mem_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_req", {31'b0, mem_req}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        if_req = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'h12121212;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = '0;
        chk("rst_stray_ack", {29'b0, if_ready, dm_ready, mem_req}, 32'd0);
        @(posedge clk); #1;
        chk("rst_stray_ack2", {29'b0, if_ready, dm_ready, mem_req}, 32'd0);
        chk("rst_ifdata", if_rdata, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
